// File: rtl/onehot_scan_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : onehot_scan_encoder                                          |
// | Description : Captures an 8-bit request vector and emits the index of each |
// |               set bit once, in priority order, over a valid/ready stream.  |
// |               Optional out-of-range check: ONEHOT_SCAN_ENCODER_ERR_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module onehot_scan_encoder #(
    parameter int PRIO_LSB = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_code,
    output logic        out_last,
    output logic        busy,
    output logic        err
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SCAN = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_pending;
    logic [2:0] w_code;
    logic [7:0] w_sel;
    logic       w_single;
    logic       w_capture;

    assign w_capture = (r_state == c_ST_IDLE) && in_valid;
    assign w_sel     = 8'b1 << w_code;
    assign w_single  = (r_pending != 8'd0) && ((r_pending & (r_pending - 8'd1)) == 8'd0);

    generate
        if (PRIO_LSB != 0) begin : g_lsb
            always_comb begin
                w_code = 3'd0;
                for (int i = 7; i >= 0; i--) begin
                    if (r_pending[i]) w_code = 3'(i);
                end
            end
        end else begin : g_msb
            always_comb begin
                w_code = 3'd0;
                for (int i = 0; i < 8; i++) begin
                    if (r_pending[i]) w_code = 3'(i);
                end
            end
        end
    endgenerate

    // An all-zero capture leaves pending empty, so the block simply stays idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_pending <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_pending <= in_vec[7:0];
                        r_state   <= (in_vec[7:0] != 8'd0) ? c_ST_SCAN : c_ST_IDLE;
                    end
                end
                c_ST_SCAN: begin
                    if (out_ready) begin
                        r_pending <= r_pending & ~w_sel;
                        if (w_single) r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_pending <= 8'd0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_SCAN);
    assign out_code  = w_code;
    assign out_last  = out_valid && w_single;
    assign busy      = (r_pending != 8'd0);

`ifdef ONEHOT_SCAN_ENCODER_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_capture && (in_vec[15:8] != 8'd0);
        end
    end

    assign err = r_err;
`else
    // Upper request bits are only consumed by the optional range check.
    logic w_unused_hi;
    assign w_unused_hi = &{1'b0, in_vec[15:8], w_capture};
    assign err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_onehot_scan_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_onehot_scan_encoder                                       |
// | Description : Scoreboard bench for onehot_scan_encoder, both scan orders.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_onehot_scan_encoder;

`ifdef ONEHOT_SCAN_ENCODER_ERR_EN
    localparam int c_ERR_EN = 1;
`else
    localparam int c_ERR_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_vec;
    logic        out_ready;

    logic        in_ready_l, out_valid_l, out_last_l, busy_l, err_l;
    logic [2:0]  out_code_l;
    logic        in_ready_m, out_valid_m, out_last_m, busy_m, err_m;
    logic [2:0]  out_code_m;

    int checks = 0;
    int errors = 0;
    int hs_l   = 0;
    int hs_m   = 0;

    // Each entry is {last, code}.
    logic [3:0] q_l[$];
    logic [3:0] q_m[$];

    always #5 clk = ~clk;

    onehot_scan_encoder #(.PRIO_LSB(1)) u_dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_code(out_code_l), .out_last(out_last_l), .busy(busy_l), .err(err_l)
    );

    onehot_scan_encoder #(.PRIO_LSB(0)) u_dut_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_code(out_code_m), .out_last(out_last_m), .busy(busy_m), .err(err_m)
    );

    always @(negedge clk) begin : mon
        logic [3:0] e;
        if (!reset) begin
            if (out_valid_l && out_ready) begin
                hs_l++;
                checks++;
                if (q_l.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_unexpected_code got code=%0d last=%0d, required none", out_code_l, out_last_l);
                end else begin
                    e = q_l.pop_front();
                    if ({out_last_l, out_code_l} !== e) begin
                        errors++;
                        $display("FAIL lsb_code got code=%0d last=%0d, required code=%0d last=%0d",
                                 out_code_l, out_last_l, e[2:0], e[3]);
                    end
                end
            end
            if (out_valid_m && out_ready) begin
                hs_m++;
                checks++;
                if (q_m.size() == 0) begin
                    errors++;
                    $display("FAIL msb_unexpected_code got code=%0d last=%0d, required none", out_code_m, out_last_m);
                end else begin
                    e = q_m.pop_front();
                    if ({out_last_m, out_code_m} !== e) begin
                        errors++;
                        $display("FAIL msb_code got code=%0d last=%0d, required code=%0d last=%0d",
                                 out_code_m, out_last_m, e[2:0], e[3]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        int total;
        int k;
        total = $countones(v);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                k++;
                q_l.push_back({(k == total), 3'(i)});
            end
        end
        k = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                k++;
                q_m.push_back({(k == total), 3'(i)});
            end
        end
    endtask

    task automatic capture(input logic [15:0] v);
        in_vec   = v;
        in_valid = 1'b1;
        push(v[7:0]);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready_l && in_ready_m) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got busy, required idle within 40 cycles");
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {in_ready_l, in_ready_m},   2'b11);
        chk({tag, "_out_valid"}, {out_valid_l, out_valid_m}, 2'b00);
        chk({tag, "_out_code"},  {out_code_l, out_code_m},   6'd0);
        chk({tag, "_out_last"},  {out_last_l, out_last_m},   2'b00);
        chk({tag, "_busy"},      {busy_l, busy_m},           2'b00);
        chk({tag, "_err"},       {err_l, err_m},             2'b00);
    endtask

    initial begin
        int hs0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 16'h0000;
        out_ready = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Lowest-first stream at full throughput.
        out_ready = 1'b1;
        capture(16'h0025);
        chk("t1_valid_c0", {out_valid_l, out_code_l, out_last_l}, {1'b1, 3'd0, 1'b0});
        chk("t1_msb_c0",   {out_valid_m, out_code_m, out_last_m}, {1'b1, 3'd5, 1'b0});
        chk("t1_in_ready_scan", in_ready_l, 0);
        chk("t1_err", err_l, 0);
        tick();
        chk("t1_c1", {out_code_l, out_last_l}, {3'd2, 1'b0});
        tick();
        chk("t1_c2", {out_code_l, out_last_l}, {3'd5, 1'b1});
        tick();
        chk("t1_done", {in_ready_l, out_valid_l, busy_l}, 3'b100);
        wait_idle();

        // Highest-first with a stall on the final code.
        capture(16'h0081);
        chk("t2_msb_c0", {out_code_m, out_last_m}, {3'd7, 1'b0});
        tick();
        out_ready = 1'b0;
        chk("t2_msb_c1", {out_valid_m, out_code_m, out_last_m}, {1'b1, 3'd0, 1'b1});
        tick();
        chk("t2_msb_hold", {out_valid_m, out_code_m, out_last_m}, {1'b1, 3'd0, 1'b1});
        chk("t2_lsb_hold", {out_valid_l, out_code_l, out_last_l}, {1'b1, 3'd7, 1'b1});
        out_ready = 1'b1;
        tick();
        chk("t2_done", {in_ready_m, out_valid_m}, 2'b10);
        wait_idle();

        // Empty capture produces nothing.
        capture(16'h0000);
        chk("t3_idle", {in_ready_l, out_valid_l, busy_l, in_ready_m, out_valid_m, busy_m}, 6'b100100);
        tick();
        chk("t3_idle2", {in_ready_l, out_valid_l, busy_l}, 3'b100);

        // Out-of-range upper bits with all eight codes.
        hs0 = hs_l;
        capture(16'h01FF);
        chk("t4_err_pulse", {err_l, err_m}, c_ERR_EN ? 2'b11 : 2'b00);
        tick();
        chk("t4_err_clear", {err_l, err_m}, 2'b00);
        wait_idle();
        chk("t4_handshakes", hs_l - hs0, 8);

        // Upper bits alone with an empty encoded field still flag err.
        capture(16'h8000);
        chk("t4b_err_pulse", err_l, c_ERR_EN);
        chk("t4b_no_valid", out_valid_l, 0);
        tick();

        // Reset mid-scan abandons the remaining codes.
        capture(16'h00F0);
        tick();
        tick();
        chk("t5_third", {out_code_l, out_code_m}, {3'd6, 3'd5});
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        q_l.delete();
        q_m.delete();
        chk_reset_outputs("t5_rst");
        reset     = 1'b0;
        out_ready = 1'b1;
        capture(16'h0002);
        chk("t5_single", {out_valid_l, out_code_l, out_last_l}, {1'b1, 3'd1, 1'b1});
        tick();
        chk("t5_done", {in_ready_l, out_valid_l}, 2'b10);
        wait_idle();

        // in_vec changes while scanning must not disturb the captured vector.
        out_ready = 1'b0;
        capture(16'h0003);
        in_valid = 1'b1;
        in_vec   = 16'h00F0;
        tick();
        in_vec = 16'hFF0C;
        tick();
        chk("t6_hold", {out_code_l, out_code_m}, {3'd0, 3'd1});
        chk("t6_err", err_l, 0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_vec   = 16'h0000;
        chk("t6_second", {out_code_l, out_last_l}, {3'd1, 1'b1});
        tick();
        chk("t6_done", {in_ready_l, busy_l, in_ready_m, busy_m}, 4'b1010);
        wait_idle();

        tick();
        chk("queues_drained", q_l.size() + q_m.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
